// File: rtl/ysyx_23060332_mem_arbiter.sv
// rtl/ysyx_23060332_mem_arbiter.sv - IFU/LSU arbiter for the shared data-memory port with watchdog
// Optional feature: define YSYX_23060332_ARB_RR_EN for round-robin tie-breaking (default: fixed LSU priority).
module ysyx_23060332_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rsp_data,
  output logic              ifu_rsp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_data,
  output logic              lsu_rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

  state_e            state_q;
  logic              owner_q;      // 1 = LSU owns the transaction, 0 = IFU
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wmask_q;
  logic [15:0]       wdog_q;
  logic [15:0]       wdog_d;
  logic              ifu_rsp_valid_q, lsu_rsp_valid_q;
  logic              ifu_rsp_err_q, lsu_rsp_err_q;
  logic [DATA_W-1:0] ifu_rsp_data_q, lsu_rsp_data_q;

  logic              arb_en;
  logic              grant_lsu;
  logic              rsp_normal;
  logic              rsp_tmo;
  logic [DATA_W-1:0] rsp_data_d;

`ifdef YSYX_23060332_ARB_RR_EN
  logic last_grant_q;  // 1 = LSU was granted last
  // Tie goes to whichever requester was not granted last time
  always_comb begin
    grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_grant_q);
  end
`else
  // Fixed priority: LSU always beats IFU
  always_comb begin
    grant_lsu = lsu_req_valid;
  end
`endif

  // Grant and response decode; readies are held low while reset is asserted
  always_comb begin
    arb_en        = (state_q == S_IDLE) & rst;
    lsu_req_ready = arb_en & grant_lsu;
    ifu_req_ready = arb_en & ifu_req_valid & ~grant_lsu;
    wdog_d        = wdog_q + 16'd1;
    rsp_normal    = ((state_q == S_WAIT) & mem_rsp_valid) |
                    ((state_q == S_REQ) & mem_req_ready & mem_rsp_valid);
    rsp_tmo       = ~rsp_normal & (state_q != S_IDLE) & (wdog_d == TMO);
    // Store acks and timeouts carry zero data
    rsp_data_d    = (rsp_normal & ~(owner_q & wen_q)) ? mem_rsp_data : '0;
  end

  // Transaction FSM with latched request fields and registered response pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      owner_q         <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      wdog_q          <= '0;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      ifu_rsp_err_q   <= 1'b0;
      lsu_rsp_err_q   <= 1'b0;
      ifu_rsp_data_q  <= '0;
      lsu_rsp_data_q  <= '0;
`ifdef YSYX_23060332_ARB_RR_EN
      last_grant_q    <= 1'b1;
`endif
    end else begin
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (lsu_req_ready) begin
            owner_q <= 1'b1;
            addr_q  <= lsu_addr;
            wen_q   <= lsu_wen;
            wdata_q <= lsu_wdata;
            wmask_q <= lsu_wen ? lsu_wmask : 8'h00;
            wdog_q  <= '0;
            state_q <= S_REQ;
`ifdef YSYX_23060332_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
          end else if (ifu_req_ready) begin
            owner_q <= 1'b0;
            addr_q  <= ifu_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= 8'h00;
            wdog_q  <= '0;
            state_q <= S_REQ;
`ifdef YSYX_23060332_ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
          end
        end
        S_REQ, S_WAIT: begin
          wdog_q <= wdog_d;
          if (rsp_normal || rsp_tmo) begin
            if (owner_q) begin
              lsu_rsp_valid_q <= 1'b1;
              lsu_rsp_data_q  <= rsp_data_d;
              lsu_rsp_err_q   <= rsp_tmo;
            end else begin
              ifu_rsp_valid_q <= 1'b1;
              ifu_rsp_data_q  <= rsp_data_d;
              ifu_rsp_err_q   <= rsp_tmo;
            end
            state_q <= S_IDLE;
          end else if ((state_q == S_REQ) && mem_req_ready) begin
            state_q <= S_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rsp_data  = ifu_rsp_data_q;
  assign ifu_rsp_err   = ifu_rsp_err_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rsp_data  = lsu_rsp_data_q;
  assign lsu_rsp_err   = lsu_rsp_err_q;

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// tb/tb_ysyx_23060332_mem_arbiter.sv - directed scoreboard bench for ysyx_23060332_mem_arbiter
module tb_ysyx_23060332_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [63:0] ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [63:0] lsu_rsp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;

  always #5 clk = ~clk;

  ysyx_23060332_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  typedef struct {
    logic        lsu;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Called during the REQ cycle: accept now, respond in the following cycle
  task automatic serve(input logic [63:0] d);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    step();
    mem_rsp_valid = 1'b0;
  endtask

  // Response monitor: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    if (ifu_rsp_valid || lsu_rsp_valid) begin
      chk("rsp_both", {63'd0, ifu_rsp_valid & lsu_rsp_valid}, 64'd0);
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        got = sb.pop_front();
        chk("rsp_port", {63'd0, lsu_rsp_valid}, {63'd0, got.lsu});
        chk("rsp_data", lsu_rsp_valid ? lsu_rsp_data : ifu_rsp_data, got.data);
        chk("rsp_err", {63'd0, lsu_rsp_valid ? lsu_rsp_err : ifu_rsp_err}, {63'd0, got.err});
      end
    end
  end

  initial begin
    logic        exp_lsu;
    logic [63:0] d;
    rst = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    // Reset with IFU request pending
    smp(); smp();
    chk("rst_ifu_ready", {63'd0, ifu_req_ready}, 64'd0);
    chk("rst_lsu_ready", {63'd0, lsu_req_ready}, 64'd0);
    chk("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_ifu_rsp",   {63'd0, ifu_rsp_valid}, 64'd0);
    chk("rst_lsu_rsp",   {63'd0, lsu_rsp_valid}, 64'd0);
    chk("rst_mem_addr",  {32'd0, mem_addr}, 64'd0);

    // IFU read
    step(); rst = 1'b1;
    smp();
    chk("ifu_ready", {63'd0, ifu_req_ready}, 64'd1);
    chk("ifu_lsu_ready", {63'd0, lsu_req_ready}, 64'd0);
    step(); ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    smp();
    chk("ifu_mem_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("ifu_mem_addr", {32'd0, mem_addr}, 64'h8000_0000);
    chk("ifu_mem_wen", {63'd0, mem_wen}, 64'd0);
    chk("ifu_mem_wmask", {56'd0, mem_wmask}, 64'd0);
    chk("ifu_mem_wdata", mem_wdata, 64'd0);
    step(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0000_0013_0000_0093;
    sb.push_back('{1'b0, 64'h0000_0013_0000_0093, 1'b0});
    step(); mem_rsp_valid = 1'b0;
    smp();
    chk("ifu_rsp_pulse", {63'd0, ifu_rsp_valid}, 64'd1);
    chk("ifu_no_lsu_rsp", {63'd0, lsu_rsp_valid}, 64'd0);
    step(); smp();
    chk("ifu_rsp_one_cycle", {63'd0, ifu_rsp_valid}, 64'd0);

    // LSU store
    step();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 64'h0000_0000_dead_beef; lsu_wmask = 8'h0f;
    smp();
    chk("st_ready", {63'd0, lsu_req_ready}, 64'd1);
    step(); lsu_req_valid = 1'b0;
    smp();
    chk("st_mem_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("st_mem_addr", {32'd0, mem_addr}, 64'h8000_1000);
    chk("st_mem_wen", {63'd0, mem_wen}, 64'd1);
    chk("st_mem_wdata", mem_wdata, 64'h0000_0000_dead_beef);
    chk("st_mem_wmask", {56'd0, mem_wmask}, 64'h0f);
    sb.push_back('{1'b1, 64'd0, 1'b0});
    serve(64'h1234_5678_9abc_def0);
    smp();

    // Three simultaneous IFU+LSU(load) requests
    for (int i = 0; i < 3; i++) begin
      step();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100 + 32'(i * 8);
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000 + 32'(i * 8);
      lsu_wen = 1'b0; lsu_wmask = 8'hff; lsu_wdata = 64'h5555;
`ifdef YSYX_23060332_ARB_RR_EN
      exp_lsu = (i == 1);
`else
      exp_lsu = 1'b1;
`endif
      smp();
      chk("tie_ifu_ready", {63'd0, ifu_req_ready}, {63'd0, ~exp_lsu});
      chk("tie_lsu_ready", {63'd0, lsu_req_ready}, {63'd0, exp_lsu});
      step(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      smp();
      chk("tie_mem_addr", {32'd0, mem_addr},
          exp_lsu ? 64'h8000_2000 + 64'(i * 8) : 64'h8000_0100 + 64'(i * 8));
      chk("tie_mem_wen", {63'd0, mem_wen}, 64'd0);
      chk("tie_mem_wmask", {56'd0, mem_wmask}, 64'd0);
      d = 64'hc0de_0000_0000_0000 + 64'(i);
      sb.push_back('{exp_lsu, d, 1'b0});
      serve(d);
      smp();
    end

    // Watchdog: memory never accepts
    step(); ifu_req_valid = 1'b1; ifu_addr = 32'h8000_3000;
    step(); ifu_req_valid = 1'b0;
    sb.push_back('{1'b0, 64'd0, 1'b1});
    for (int k = 1; k <= 4; k++) begin
      smp();
      chk("tmo_mem_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("tmo_no_rsp_yet", {63'd0, ifu_rsp_valid}, 64'd0);
      step();
    end
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_4000; lsu_wen = 1'b0;
    smp();
    chk("tmo_rsp_valid", {63'd0, ifu_rsp_valid}, 64'd1);
    chk("tmo_mem_dropped", {63'd0, mem_req_valid}, 64'd0);
    chk("tmo_idle_ready", {63'd0, lsu_req_ready}, 64'd1);

    // Reset while waiting for a response; the late response must be dropped
    step(); lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step(); mem_req_ready = 1'b0; rst = 1'b0;
    smp();
    chk("rstw_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    step(); rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h7777;
    step(); mem_rsp_valid = 1'b0;
    smp();
    chk("rstw_lsu_rsp", {63'd0, lsu_rsp_valid}, 64'd0);
    chk("rstw_ifu_rsp", {63'd0, ifu_rsp_valid}, 64'd0);
    step(); smp();
    chk("rstw_lsu_rsp2", {63'd0, lsu_rsp_valid}, 64'd0);

    step(); step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
